// File: rtl/proc_pkg.sv
// Shared processor definitions: ALU opcodes, datapath widths and the
// immediate extension helper used by the operand stage.
package proc_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int IMM_W     = 16;
  localparam int REG_COUNT = 32;

  localparam logic [3:0] SUM                = 4'b0000;
  localparam logic [3:0] SUBTRACT           = 4'b0001;
  localparam logic [3:0] MULTIPLY           = 4'b0010;
  localparam logic [3:0] DIVIDE             = 4'b0011;
  localparam logic [3:0] BITWISE_NOT        = 4'b0110;
  localparam logic [3:0] LOGIC_EQUAL        = 4'b1010;
  localparam logic [3:0] LOGIC_DIFFERENT    = 4'b1011;
  localparam logic [3:0] LOGIC_GREATER_THAN = 4'b1100;
  localparam logic [3:0] LOGIC_LESS_THAN    = 4'b1101;

  function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                   input logic             sign_ext);
    logic fill;
    fill = sign_ext & imm[IMM_W-1];
    return {{(DATA_W-IMM_W){fill}}, imm};
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports with same-cycle
// writeback bypass, one write port, R0 hardwired to zero.
module regfile_2r1w
  import proc_pkg::*;
#(
  parameter int DATA_W_P    = DATA_W,
  parameter int ADDR_W_P    = ADDR_W,
  parameter int REG_COUNT_P = REG_COUNT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W_P-1:0] ra_addr,
  input  logic [ADDR_W_P-1:0] rb_addr,
  output logic [DATA_W_P-1:0] ra_data,
  output logic [DATA_W_P-1:0] rb_data,
  input  logic                wb_en,
  input  logic [ADDR_W_P-1:0] wb_addr,
  input  logic [DATA_W_P-1:0] wb_data
);

  logic [DATA_W_P-1:0] regs [REG_COUNT_P];
  logic                wb_live;

  assign wb_live = wb_en && (wb_addr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT_P; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Index 0 never reads the array or the bypass, so a stray write to R0 is invisible.
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr != '0) ra_data = (wb_live && wb_addr == ra_addr) ? wb_data : regs[ra_addr];
    if (rb_addr != '0) rb_data = (wb_live && wb_addr == rb_addr) ? wb_data : regs[rb_addr];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: reads operands, substitutes immediates and
// holds them in one valid/ready slot that tracks writebacks while stalled.
module alu_operand_stage
  import proc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic              sign_ext,
  input  logic [3:0]        sel_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [3:0]        selALU,
  output logic [ADDR_W-1:0] rd_out
);

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] op2_next;
  logic [ADDR_W-1:0] src_rs;
  logic [ADDR_W-1:0] src_rt;
  logic              imm_flag;
  logic              capture;
  logic              wb_live;

  regfile_2r1w u_regfile (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (rs_addr),
    .rb_addr (rt_addr),
    .ra_data (rs_data),
    .rb_data (rt_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // Handshake: a transfer happens on a cycle where valid and ready are both high.
  // Upstream holds its payload until in_ready; the slot holds its payload until
  // out_ready. A flush cancels capture, so an instruction accepted then is dropped.
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign wb_live  = wb_en && (wb_addr != '0);
  assign op2_next = use_imm ? extend_imm(imm, sign_ext) : rt_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      selALU    <= SUM;
      rd_out    <= '0;
      src_rs    <= '0;
      src_rt    <= '0;
      imm_flag  <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      op1       <= rs_data;
      op2       <= op2_next;
      selALU    <= sel_in;
      rd_out    <= rd_in;
      src_rs    <= rs_addr;
      src_rt    <= rt_addr;
      imm_flag  <= use_imm;
    end else begin
      if (flush || (out_valid && out_ready)) out_valid <= 1'b0;
      // Keep a held operand current with writebacks that land after its read.
      if (out_valid && wb_live) begin
        if (wb_addr == src_rs)              op1 <= wb_data;
        if (wb_addr == src_rt && !imm_flag) op2 <= wb_data;
      end
    end
  end

endmodule
